// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: pixel divider, scan counters, syncs, markers
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [15:0] xcount,
  output logic [15:0] ycount,
  output logic        active_video,
  output logic        pix_en,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider terminal count; CLK_DIV tops out at 16, so 5 bits always suffice.
  localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);

  // Phase boundaries as 16-bit constants so all compares are width-matched.
  localparam logic [15:0] H_A_END = 16'(H_ACTIVE);
  localparam logic [15:0] H_F_END = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_S_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_A_END = 16'(V_ACTIVE);
  localparam logic [15:0] V_F_END = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_S_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // Phase is a pure function of position, so it is derived from the next
  // counter value and registered alongside it: outputs never skew.
  function automatic phase_t phase_of(
    input logic [15:0] pos,
    input logic [15:0] a_end,
    input logic [15:0] f_end,
    input logic [15:0] s_end
  );
    phase_t ph;
    if (pos < a_end) begin
      ph = PH_ACTIVE;
    end else if (pos < f_end) begin
      ph = PH_FRONT;
    end else if (pos < s_end) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

  logic [4:0]  div_cnt;
  logic        adv;
  logic        x_wrap;
  logic        y_wrap;
  logic [15:0] x_next;
  logic [15:0] y_next;
  phase_t      h_phase_next;
  phase_t      v_phase_next;
  logic        hs_next;
  logic        vs_next;
  logic        active_next;

  // Pixel-rate divider: returns to 0 on each advance edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 5'd0;
    end else if (adv) begin
      div_cnt <= 5'd0;
    end else begin
      div_cnt <= div_cnt + 5'd1;
    end
  end

  // Next scan position and the phase/sync/active values that go with it.
  always_comb begin
    adv          = (div_cnt == DIV_LAST);
    x_wrap       = (xcount == H_LAST);
    y_wrap       = (ycount == V_LAST);
    x_next       = xcount + 16'd1;
    y_next       = ycount;
    if (x_wrap) begin
      x_next = 16'd0;
      y_next = y_wrap ? 16'd0 : ycount + 16'd1;
    end
    h_phase_next = phase_of(x_next, H_A_END, H_F_END, H_S_END);
    v_phase_next = phase_of(y_next, V_A_END, V_F_END, V_S_END);
    hs_next      = (h_phase_next != PH_SYNC);
    vs_next      = (v_phase_next != PH_SYNC);
    active_next  = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
  end

  // Scan position and all timing outputs; they move together on advance edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcount       <= 16'd0;
      ycount       <= 16'd0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      active_video <= 1'b1;
      pix_en       <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (adv) begin
      xcount       <= x_next;
      ycount       <= y_next;
      VGA_HS       <= hs_next;
      VGA_VS       <= vs_next;
      active_video <= active_next;
      pix_en       <= 1'b1;
      line_start   <= x_wrap;
      frame_start  <= x_wrap && y_wrap;
    end else begin
      pix_en       <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

endmodule
